// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared types and constants for the store buffer
package store_pkg;

    typedef enum logic [2:0] {
        ST_BYTE = 3'b000,
        ST_HALF = 3'b001,
        ST_WORD = 3'b010
    } store_type_e;

    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_format.sv
// rtl/store_format.sv - lane replication, byte enables and alignment check for one store
module store_format
    import store_pkg::*;
(
    input  logic [31:0] A,
    input  logic [2:0]  Type,
    input  logic [31:0] WD,
    output logic [31:0] data,
    output logic [3:0]  be,
    output logic        fault
);

    always_comb begin
        data  = WD;
        be    = 4'b0000;
        fault = 1'b0;
        case (store_type_e'(Type))
            ST_BYTE: begin
                data = {4{WD[7:0]}};
                be   = BE_BYTE << A[1:0];
            end
            ST_HALF: begin
                data  = {2{WD[15:0]}};
                be    = A[1] ? BE_HI : BE_LO;
                fault = A[0];
            end
            ST_WORD: begin
                data  = WD;
                be    = BE_ALL;
                fault = |A[1:0];
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue toward memory with load-hazard detection
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        InValid,
    output logic        InReady,
    input  logic [2:0]  Type,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic        Fault,
    output logic        MemReq,
    input  logic        MemAck,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWD,
    output logic [3:0]  MemBE,
    input  logic [31:0] LdAddr,
    output logic        LdHazard,
    output logic        Empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    sb_entry_t     mem [DEPTH];

    logic [31:0] fmt_data;
    logic [3:0]  fmt_be;
    logic        fmt_fault;
    logic        accept;
    logic        push;
    logic        pop;
    sb_entry_t   head_entry;
    logic [PW-1:0] offset;

    store_format u_format (
        .A     (A),
        .Type  (Type),
        .WD    (WD),
        .data  (fmt_data),
        .be    (fmt_be),
        .fault (fmt_fault)
    );

    assign InReady = (count != FULL_COUNT);
    assign MemReq  = (count != '0);
    assign Empty   = !MemReq;
    assign accept  = InValid && InReady;
    assign push    = accept && !fmt_fault;
    assign pop     = MemReq && MemAck;

    assign head_entry = mem[head];
    assign MemAddr    = head_entry.addr;
    assign MemWD      = head_entry.data;
    assign MemBE      = head_entry.be;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            Fault <= 1'b0;
        end else begin
            Fault <= accept && fmt_fault;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is never reset; validity is carried entirely by head/count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail] <= '{addr: {A[31:2], 2'b00}, data: fmt_data, be: fmt_be};
        end
    end

    // An entry is live when its distance from head is below the occupancy count.
    always_comb begin
        LdHazard = 1'b0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head;
            if (({1'b0, offset} < count) &&
                (((mem[i].addr ^ LdAddr) & ADDR_WORD_MASK) == 32'h0)) begin
                LdHazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        InValid;
    logic        InReady;
    logic [2:0]  Type;
    logic [31:0] A;
    logic [31:0] WD;
    logic        Fault;
    logic        MemReq;
    logic        MemAck;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic [3:0]  MemBE;
    logic [31:0] LdAddr;
    logic        LdHazard;
    logic        Empty;

    int n_checks = 0;
    int n_fails  = 0;

    store_buffer #(.DEPTH(4)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .InValid  (InValid),
        .InReady  (InReady),
        .Type     (Type),
        .A        (A),
        .WD       (WD),
        .Fault    (Fault),
        .MemReq   (MemReq),
        .MemAck   (MemAck),
        .MemAddr  (MemAddr),
        .MemWD    (MemWD),
        .MemBE    (MemBE),
        .LdAddr   (LdAddr),
        .LdHazard (LdHazard),
        .Empty    (Empty)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        InValid = v;
        Type    = t;
        A       = a;
        WD      = d;
    endtask

    initial begin
        RSTn    = 1'b0;
        MemAck  = 1'b0;
        LdAddr  = 32'h0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        step();
        step();
        chk("rst_memreq",   {31'h0, MemReq},   32'h0);
        chk("rst_fault",    {31'h0, Fault},    32'h0);
        chk("rst_empty",    {31'h0, Empty},    32'h1);
        chk("rst_inready",  {31'h0, InReady},  32'h1);
        chk("rst_ldhazard", {31'h0, LdHazard}, 32'h0);
        RSTn = 1'b1;
        step();

        // byte store at lane 3
        drive(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
        #1;
        chk("sb_no_bypass", {31'h0, MemReq}, 32'h0);
        step();
        InValid = 1'b0;
        chk("sb_memreq", {31'h0, MemReq}, 32'h1);
        chk("sb_addr",   MemAddr, 32'h0000_1000);
        chk("sb_wd",     MemWD,   32'hABAB_ABAB);
        chk("sb_be",     {28'h0, MemBE}, 32'h8);
        chk("sb_fault",  {31'h0, Fault}, 32'h0);
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        chk("sb_pop_empty", {31'h0, Empty}, 32'h1);

        // legal half followed by misaligned word
        drive(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234);
        step();
        drive(1'b1, 3'b010, 32'h0000_2005, 32'hDEAD_BEEF);
        step();
        InValid = 1'b0;
        chk("sw_mis_fault", {31'h0, Fault}, 32'h1);
        chk("sh_addr", MemAddr, 32'h0000_2000);
        chk("sh_wd",   MemWD,   32'h1234_1234);
        chk("sh_be",   {28'h0, MemBE}, 32'hC);
        step();
        chk("fault_one_cycle", {31'h0, Fault}, 32'h0);
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        chk("fault_not_queued", {31'h0, Empty}, 32'h1);

        // illegal type code and misaligned half
        drive(1'b1, 3'b101, 32'h0000_2100, 32'h1);
        step();
        drive(1'b1, 3'b001, 32'h0000_2101, 32'h2);
        chk("illegal_fault", {31'h0, Fault}, 32'h1);
        step();
        InValid = 1'b0;
        chk("sh_mis_fault", {31'h0, Fault}, 32'h1);
        chk("faults_empty", {31'h0, Empty}, 32'h1);
        step();

        // fill, hold a fifth, pop once, drain across pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b010, 32'h0000_4000 + 32'(4 * i), 32'(i + 1));
            step();
        end
        drive(1'b1, 3'b010, 32'h0000_4010, 32'h5);
        chk("full_inready", {31'h0, InReady}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_inready", {31'h0, InReady}, 32'h0);
            chk("held_head",    MemAddr, 32'h0000_4000);
        end
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        chk("after_pop_inready", {31'h0, InReady}, 32'h1);
        chk("after_pop_head",    MemAddr, 32'h0000_4004);
        step();
        InValid = 1'b0;
        chk("refull_inready", {31'h0, InReady}, 32'h0);
        MemAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", MemAddr, 32'h0000_4004 + 32'(4 * i));
            chk("drain_wd",   MemWD,   32'(i + 2));
            step();
        end
        MemAck = 1'b0;
        chk("drain_empty", {31'h0, Empty}, 32'h1);

        // load hazard against a queued word
        drive(1'b1, 3'b010, 32'h0000_3000, 32'h7777_7777);
        step();
        InValid = 1'b0;
        LdAddr = 32'h0000_3002;
        #1;
        chk("haz_same_word", {31'h0, LdHazard}, 32'h1);
        LdAddr = 32'h0000_3004;
        #1;
        chk("haz_next_word", {31'h0, LdHazard}, 32'h0);
        LdAddr = 32'h0000_3000;
        MemAck = 1'b1;
        #1;
        chk("haz_while_pop", {31'h0, LdHazard}, 32'h1);
        step();
        MemAck = 1'b0;
        chk("haz_after_pop", {31'h0, LdHazard}, 32'h0);
        chk("haz_empty",     {31'h0, Empty},    32'h1);

        // asynchronous reset with queued stores and a pending ack
        drive(1'b1, 3'b010, 32'h0000_5000, 32'h1);
        step();
        drive(1'b1, 3'b010, 32'h0000_5004, 32'h2);
        step();
        InValid = 1'b0;
        LdAddr  = 32'h0000_5000;
        chk("pre_rst_memreq", {31'h0, MemReq}, 32'h1);
        MemAck = 1'b1;
        #3;
        RSTn = 1'b0;
        #1;
        chk("arst_memreq",   {31'h0, MemReq},   32'h0);
        chk("arst_empty",    {31'h0, Empty},    32'h1);
        chk("arst_inready",  {31'h0, InReady},  32'h1);
        chk("arst_ldhazard", {31'h0, LdHazard}, 32'h0);
        #2;
        MemAck = 1'b0;
        RSTn   = 1'b1;
        step();
        step();
        chk("post_rst_idle", {31'h0, MemReq}, 32'h0);
        drive(1'b1, 3'b000, 32'h0000_6001, 32'h0000_005A);
        step();
        InValid = 1'b0;
        chk("post_rst_addr", MemAddr, 32'h0000_6000);
        chk("post_rst_wd",   MemWD,   32'h5A5A_5A5A);
        chk("post_rst_be",   {28'h0, MemBE}, 32'h2);
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        chk("post_rst_no_stale", {31'h0, MemReq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
